if_fetch_unit: RTL

//  Instruction-fetch stage: owns the architectural fetch PC and issues sequential word fetches to

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/if_fetch_unit_if.sv | 33 +++
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_queue_chk.sv | 17 +
 rtl/if_fetch_unit.sv | 104 ++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic {
      REQ  = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } fq_entry_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch addresses are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle of the fetch stage: redirect input, imem req/resp and the IF/ID handshake.
interface if_fetch_unit_if;

   logic        ex_take_branch_in;
   logic [31:0] ex_target_PC_in;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_id_valid;
   logic [31:0] if_id_PC;
   logic [31:0] if_id_NPC;
   logic [31:0] if_id_IR;
   logic        id_if_ready;

   modport master (
      input  ex_take_branch_in, ex_target_PC_in,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      output if_id_valid, if_id_PC, if_id_NPC, if_id_IR,
      input  id_if_ready
   );

   modport slave (
      output ex_take_branch_in, ex_target_PC_in,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      input  if_id_valid, if_id_PC, if_id_NPC, if_id_IR,
      output id_if_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, ir} entries; flush empties it in one cycle.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fq_entry_t                wdata,
   output fq_entry_t                head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   fq_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // Pointer and occupancy bookkeeping; flush wins over push/pop.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; a push on a full queue is only legal alongside a pop of the same slot.
   always_ff @(posedge clk) begin
      if (rst && !flush && push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_chk.sv
// Protocol checker for the fetch queue: no net push into a full queue.
module fetch_queue_chk #(
   parameter int DEPTH = 2
) (
   input logic                   clk,
   input logic                   rst,
   input logic                   push,
   input logic                   pop,
   input logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem requests, fetch queue toward decode.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          FQ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   if_fetch_unit_if.master  bus
);

   localparam int              CW      = $clog2(FQ_DEPTH) + 1;
   localparam logic [CW-1:0]   FQ_FULL = CW'(FQ_DEPTH);

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          drop_resp;
   logic [CW-1:0] fq_count;
   fq_entry_t     fq_head;
   fq_entry_t     fq_wdata;
   logic          redirect;
   logic          req_valid;
   logic          req_fire;
   logic          resp_hit;
   logic          push;
   logic          pop;
   logic          fq_valid;

   assign redirect  = bus.ex_take_branch_in;
   // In REQ nothing is outstanding, so a free slot now is still free when the response lands.
   assign req_valid = rst && (state == REQ) && (fq_count < FQ_FULL) && !redirect;
   assign req_fire  = req_valid && bus.imem_req_ready;
   assign resp_hit  = rst && (state == WAIT) && bus.imem_resp_valid;
   assign push      = resp_hit && !drop_resp && !redirect;
   assign fq_valid  = (fq_count != '0);
   assign pop       = rst && fq_valid && bus.id_if_ready && !redirect;
   assign fq_wdata  = '{pc: req_pc, ir: bus.imem_resp_data};

   // Fetch FSM: redirect overrides the normal request/response sequencing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= REQ;
         fetch_pc  <= RESET_PC;
         req_pc    <= RESET_PC;
         drop_resp <= 1'b0;
      end else if (redirect) begin
         fetch_pc <= word_align(bus.ex_target_PC_in);
         if (state == WAIT) begin
            if (bus.imem_resp_valid) begin
               state     <= REQ;
               drop_resp <= 1'b0;
            end else begin
               drop_resp <= 1'b1;
            end
         end
      end else begin
         case (state)
            REQ: begin
               if (req_fire) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + 32'd4;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_resp_valid) begin
                  drop_resp <= 1'b0;
                  state     <= REQ;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

   fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (fq_wdata),
      .head  (fq_head),
      .count (fq_count)
   );

   fetch_queue_chk #(.DEPTH(FQ_DEPTH)) u_fetch_queue_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .count (fq_count)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.if_id_valid    = fq_valid;
   assign bus.if_id_PC       = fq_valid ? fq_head.pc : 32'd0;
   assign bus.if_id_NPC      = fq_valid ? (fq_head.pc + 32'd4) : 32'd0;
   assign bus.if_id_IR       = fq_valid ? fq_head.ir : NOP_INST;

endmodule
